// File: rtl/isq_pkg.sv
// Shared definitions for the age-ordered issue queue.
//
// Contents:
//   ISQ_DEPTH, ISQ_DATA_WIDTH, ISQ_PREG_WIDTH - default configuration values
//   ISQ_IDX_W                                 - slot index width for ISQ_DEPTH
//   isq_entry_t                               - layout of one queue slot in the
//                                               default configuration
package isq_pkg;

  localparam int ISQ_DEPTH      = 8;
  localparam int ISQ_DATA_WIDTH = 248;
  localparam int ISQ_PREG_WIDTH = 6;
  localparam int ISQ_IDX_W      = $clog2(ISQ_DEPTH);

  // Slot layout. The top module declares the same layout with its own
  // parameter widths so non-default configurations stay consistent.
  typedef struct packed {
    logic                      valid;
    logic                      busy1;
    logic                      busy2;
    logic [ISQ_PREG_WIDTH-1:0] prs1;
    logic [ISQ_PREG_WIDTH-1:0] prs2;
    logic [ISQ_DATA_WIDTH-1:0] payload;
  } isq_entry_t;

endpackage

// File: rtl/isq_age_matrix.sv
// Age matrix for the issue queue: tracks relative age of slots and grants the
// oldest requesting slot.
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   flush_i        - clear all ordering state
//   alloc_i        - one-hot slot being allocated this cycle (or zero)
//   free_i         - one-hot slot being released this cycle (or zero)
//   req_i          - slots competing for selection
//   grant_o        - one-hot oldest requesting slot (zero when no request)
//
// age_q[i][j] == 1 means slot j is older than slot i. A new slot marks every
// other slot as older; stale marks against invalid slots are harmless because
// invalid slots never request, and the column of a slot is wiped whenever it is
// (re)allocated or freed.
module isq_age_matrix
  import isq_pkg::*;
#(
  parameter int DEPTH = ISQ_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] grant_o
);

  logic [DEPTH-1:0] age_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (flush_i) begin
            age_q[i][j] <= 1'b0;
          end else if (alloc_i[i]) begin
            age_q[i][j] <= (i != j);
          end else if (alloc_i[j] || free_i[i] || free_i[j]) begin
            age_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // A requester wins when no other requester is recorded as older.
  always_comb begin
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_o[i] = req_i[i] && ((age_q[i] & req_i) == '0);
    end
  end

endmodule

// File: rtl/age_issue_queue.sv
// Age-ordered issue queue between dispatch and one functional unit.
// Entries wake by tag match against WAKE_PORTS writeback broadcasts; the oldest
// fully-ready entry is moved into a registered issue stage.
//
// Optional feature macro: ISQ_PERF_CNT_EN adds perf_issue_cnt and
// perf_full_stall_cnt outputs.
//
// Ports:
//   clock, reset_n           - clock, asynchronous active-low reset
//   enq_valid/enq_ready      - dispatch handshake; enq_data, enq_prs1/2,
//                              enq_src1/2_busy describe the entry
//   wake_valid, wake_preg    - per-channel tag broadcast (channel k at
//                              bits [k*PREG_WIDTH +: PREG_WIDTH])
//   iss_valid/iss_ready      - issue handshake; iss_data is the payload
//   flush                    - drop every entry and the issue register
//   occupancy                - valid entries, not counting the issue register
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. enq_ready depends only on registered occupancy. iss_valid and
// iss_data are registered and held unchanged while iss_valid && !iss_ready.
module age_issue_queue
  import isq_pkg::*;
#(
  parameter int DEPTH      = ISQ_DEPTH,
  parameter int DATA_WIDTH = ISQ_DATA_WIDTH,
  parameter int PREG_WIDTH = ISQ_PREG_WIDTH,
  parameter int WAKE_PORTS = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           enq_valid,
  output logic                           enq_ready,
  input  logic [DATA_WIDTH-1:0]          enq_data,
  input  logic [PREG_WIDTH-1:0]          enq_prs1,
  input  logic [PREG_WIDTH-1:0]          enq_prs2,
  input  logic                           enq_src1_busy,
  input  logic                           enq_src2_busy,
  input  logic [WAKE_PORTS-1:0]          wake_valid,
  input  logic [WAKE_PORTS*PREG_WIDTH-1:0] wake_preg,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic [DATA_WIDTH-1:0]          iss_data,
  input  logic                           flush,
  output logic [$clog2(DEPTH):0]         occupancy
`ifdef ISQ_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_issue_cnt,
  output logic [31:0]                    perf_full_stall_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic                  valid;
    logic                  busy1;
    logic                  busy2;
    logic [PREG_WIDTH-1:0] prs1;
    logic [PREG_WIDTH-1:0] prs2;
    logic [DATA_WIDTH-1:0] payload;
  } entry_t;

  entry_t                entry_q [DEPTH];
  entry_t                entry_d [DEPTH];
  logic [OCC_W-1:0]      occupancy_q, occupancy_d;
  logic                  iss_valid_q;
  logic [DATA_WIDTH-1:0] iss_data_q;

  logic [DEPTH-1:0]      valid_vec, ready_vec, alloc_oh, grant_oh, free_oh;
  logic                  alloc_found;
  logic                  enq_fire, iss_load;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic tag_hit(input logic [WAKE_PORTS-1:0]            v,
                                   input logic [WAKE_PORTS*PREG_WIDTH-1:0] tags,
                                   input logic [PREG_WIDTH-1:0]            tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WAKE_PORTS; k++) begin
      if (v[k] && (tags[k*PREG_WIDTH +: PREG_WIDTH] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign enq_ready = (occupancy_q != OCC_W'(DEPTH));
  assign enq_fire  = enq_valid && enq_ready && !flush;

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = entry_q[i].valid;
      ready_vec[i] = entry_q[i].valid && !entry_q[i].busy1 && !entry_q[i].busy2;
    end
  end

  // Lowest-index free slot, taken from registered valid bits only, so a slot
  // freed by issue this cycle is never reused in the same cycle.
  always_comb begin
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !alloc_found) begin
        alloc_oh[i] = 1'b1;
        alloc_found = 1'b1;
      end
    end
  end

  isq_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .flush_i (flush),
    .alloc_i (enq_fire ? alloc_oh : '0),
    .free_i  (free_oh),
    .req_i   (ready_vec),
    .grant_o (grant_oh)
  );

  assign iss_load = (!iss_valid_q || iss_ready) && (|ready_vec) && !flush;
  assign free_oh  = iss_load ? grant_oh : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_oh[i]) sel_data = sel_data | entry_q[i].payload;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (flush) begin
        entry_d[i].valid = 1'b0;
      end else begin
        if (free_oh[i]) entry_d[i].valid = 1'b0;
        if (tag_hit(wake_valid, wake_preg, entry_q[i].prs1)) entry_d[i].busy1 = 1'b0;
        if (tag_hit(wake_valid, wake_preg, entry_q[i].prs2)) entry_d[i].busy2 = 1'b0;
        if (enq_fire && alloc_oh[i]) begin
          entry_d[i].valid   = 1'b1;
          // A broadcast in the enqueue cycle would otherwise be missed.
          entry_d[i].busy1   = enq_src1_busy && !tag_hit(wake_valid, wake_preg, enq_prs1);
          entry_d[i].busy2   = enq_src2_busy && !tag_hit(wake_valid, wake_preg, enq_prs2);
          entry_d[i].prs1    = enq_prs1;
          entry_d[i].prs2    = enq_prs2;
          entry_d[i].payload = enq_data;
        end
      end
    end
  end

  always_comb begin
    if (flush) begin
      occupancy_d = '0;
    end else begin
      occupancy_d = occupancy_q + OCC_W'(enq_fire) - OCC_W'(iss_load);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      occupancy_q <= '0;
      iss_valid_q <= 1'b0;
      iss_data_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
      occupancy_q <= occupancy_d;
      if (flush) begin
        iss_valid_q <= 1'b0;
      end else if (iss_load) begin
        iss_valid_q <= 1'b1;
        iss_data_q  <= sel_data;
      end else if (iss_ready) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  assign iss_valid = iss_valid_q;
  assign iss_data  = iss_data_q;
  assign occupancy = occupancy_q;

`ifdef ISQ_PERF_CNT_EN
  logic [31:0] perf_issue_q, perf_stall_q;

  // Counters run through flush; only reset clears them.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (iss_valid_q && iss_ready) perf_issue_q <= perf_issue_q + 32'd1;
      if (enq_valid && !enq_ready)  perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issue_cnt      = perf_issue_q;
  assign perf_full_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_age_issue_queue.sv
// Bench for age_issue_queue: table of wakeup/bypass vectors plus hand-written
// sequences for ordering, back-pressure, flush and asynchronous reset.
// Issued payloads are checked against an expected-order queue.
module tb_age_issue_queue;

  localparam int DEPTH = 8;
  localparam int DW    = 248;
  localparam int PW    = 6;
  localparam int WP    = 2;

  logic             clock;
  logic             reset_n;
  logic             enq_valid;
  logic             enq_ready;
  logic [DW-1:0]    enq_data;
  logic [PW-1:0]    enq_prs1, enq_prs2;
  logic             enq_src1_busy, enq_src2_busy;
  logic [WP-1:0]    wake_valid;
  logic [WP*PW-1:0] wake_preg;
  logic             iss_valid;
  logic             iss_ready;
  logic [DW-1:0]    iss_data;
  logic             flush;
  logic [3:0]       occupancy;
`ifdef ISQ_PERF_CNT_EN
  logic [31:0]      perf_issue_cnt, perf_full_stall_cnt;
`endif

  age_issue_queue #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .PREG_WIDTH(PW), .WAKE_PORTS(WP)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_data      (enq_data),
    .enq_prs1      (enq_prs1),
    .enq_prs2      (enq_prs2),
    .enq_src1_busy (enq_src1_busy),
    .enq_src2_busy (enq_src2_busy),
    .wake_valid    (wake_valid),
    .wake_preg     (wake_preg),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_data      (iss_data),
    .flush         (flush),
    .occupancy     (occupancy)
`ifdef ISQ_PERF_CNT_EN
    ,
    .perf_issue_cnt      (perf_issue_cnt),
    .perf_full_stall_cnt (perf_full_stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            pushed_total = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [PW-1:0] prs1;
    logic [PW-1:0] prs2;
    logic          b1;
    logic          b2;
    logic [WP-1:0] wv;
    logic [PW-1:0] w0;
    logic [PW-1:0] w1;
    logic          exp_iss;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Handshake monitor: values seen at the falling edge are those the next
  // rising edge will act on.
  always @(negedge clock) begin
    logic [DW-1:0] e;
    if (reset_n && iss_valid && iss_ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_issue: got %0h expected none", iss_data);
      end else begin
        e = exp_q.pop_front();
        chk_d("issue_data", iss_data, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_payload();
    logic [DW-1:0] p;
    p = '0;
    repeat (8) p = {p[DW-33:0], 32'($urandom)};
    return p;
  endfunction

  task automatic push(input logic [DW-1:0] d);
    exp_q.push_back(d);
    pushed_total++;
  endtask

  task automatic drive_enq(input logic [DW-1:0] d, input logic [PW-1:0] p1,
                           input logic [PW-1:0] p2, input logic b1, input logic b2);
    enq_valid     = 1'b1;
    enq_data      = d;
    enq_prs1      = p1;
    enq_prs2      = p2;
    enq_src1_busy = b1;
    enq_src2_busy = b2;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step;
      n++;
    end
    vec_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] pl, pa, pb, p0, px;

    vt[0] = '{6'd3,  6'd4,  1'b0, 1'b0, 2'b00, 6'd0,  6'd0,  1'b1};
    vt[1] = '{6'd5,  6'd6,  1'b1, 1'b0, 2'b01, 6'd5,  6'd0,  1'b1};
    vt[2] = '{6'd5,  6'd9,  1'b0, 1'b1, 2'b10, 6'd0,  6'd9,  1'b1};
    vt[3] = '{6'd5,  6'd9,  1'b0, 1'b1, 2'b01, 6'd9,  6'd0,  1'b1};
    vt[4] = '{6'd5,  6'd9,  1'b0, 1'b1, 2'b10, 6'd0,  6'd8,  1'b0};
    vt[5] = '{6'd7,  6'd7,  1'b1, 1'b1, 2'b01, 6'd7,  6'd0,  1'b1};
    vt[6] = '{6'd7,  6'd8,  1'b1, 1'b1, 2'b11, 6'd7,  6'd8,  1'b1};
    vt[7] = '{6'd7,  6'd8,  1'b1, 1'b1, 2'b01, 6'd7,  6'd0,  1'b0};
    vt[8] = '{6'd10, 6'd11, 1'b1, 1'b0, 2'b00, 6'd10, 6'd0,  1'b0};
    vt[9] = '{6'd12, 6'd13, 1'b1, 1'b0, 2'b11, 6'd12, 6'd12, 1'b1};

    reset_n = 1'b0; enq_valid = 1'b0; enq_data = '0; enq_prs1 = '0; enq_prs2 = '0;
    enq_src1_busy = 1'b0; enq_src2_busy = 1'b0; wake_valid = '0; wake_preg = '0;
    iss_ready = 1'b0; flush = 1'b0;
    step; step;
    reset_n = 1'b1;
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk_d("rst_iss_data", iss_data, '0);
    step;

    // Table-driven wakeup/bypass vectors, one entry each, FU always ready.
    iss_ready = 1'b1;
    for (int v = 0; v < NV; v++) begin
      pl = rand_payload();
      drive_enq(pl, vt[v].prs1, vt[v].prs2, vt[v].b1, vt[v].b2);
      wake_valid = vt[v].wv;
      wake_preg  = {vt[v].w1, vt[v].w0};
      if (vt[v].exp_iss) push(pl);
      step;
      enq_valid = 1'b0; wake_valid = '0;
      chk($sformatf("v%0d_latency", v), 64'(iss_valid), 64'd0);
      step;
      chk($sformatf("v%0d_ready", v), 64'(iss_valid), 64'(vt[v].exp_iss));
      if (!vt[v].exp_iss) begin
        wake_valid = 2'b11;
        wake_preg  = {vt[v].prs2, vt[v].prs1};
        step;
        wake_valid = '0;
        push(pl);
        chk($sformatf("v%0d_wake_not_bypassed", v), 64'(iss_valid), 64'd0);
        step;
        chk($sformatf("v%0d_woken", v), 64'(iss_valid), 64'd1);
      end
      step;
      chk($sformatf("v%0d_idle_valid", v), 64'(iss_valid), 64'd0);
      chk($sformatf("v%0d_idle_occ", v), 64'(occupancy), 64'd0);
    end

    // A, B, C issue in enqueue order on consecutive cycles.
    for (int k = 0; k < 3; k++) begin
      pl = rand_payload();
      drive_enq(pl, 6'(20 + k), 6'(30 + k), 1'b0, 1'b0);
      push(pl);
      step;
      chk($sformatf("abc_valid%0d", k), 64'(iss_valid), 64'(k != 0));
    end
    enq_valid = 1'b0;
    step;
    chk("abc_valid3", 64'(iss_valid), 64'd1);
    step;
    chk("abc_done", 64'(iss_valid), 64'd0);

    // Older A waits on tag 5; younger ready B overtakes.
    pa = rand_payload();
    pb = rand_payload();
    drive_enq(pa, 6'd5, 6'd1, 1'b1, 1'b0);
    step;
    drive_enq(pb, 6'd2, 6'd3, 1'b0, 1'b0);
    push(pb);
    push(pa);
    step;
    enq_valid = 1'b0;
    wake_valid = 2'b01;
    wake_preg  = {6'd0, 6'd5};
    chk("ba_none_yet", 64'(iss_valid), 64'd0);
    step;
    wake_valid = '0;
    chk("ba_b_issued", 64'(iss_valid), 64'd1);
    step;
    chk("ba_a_issued", 64'(iss_valid), 64'd1);
    step;
    chk("ba_done", 64'(iss_valid), 64'd0);
    chk("ba_occ", 64'(occupancy), 64'd0);

    // Fill while the FU stalls: first entry sits in the issue register.
    iss_ready = 1'b0;
    p0 = '0;
    for (int k = 0; k < DEPTH + 1; k++) begin
      pl = rand_payload();
      if (k == 0) p0 = pl;
      drive_enq(pl, 6'(k), 6'(k + 1), 1'b0, 1'b0);
      push(pl);
      step;
    end
    px = rand_payload();
    drive_enq(px, 6'd40, 6'd41, 1'b0, 1'b0);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    chk("full_occ", 64'(occupancy), 64'(DEPTH));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("hold_valid%0d", k), 64'(iss_valid), 64'd1);
      chk_d($sformatf("hold_data%0d", k), iss_data, p0);
      step;
    end
    chk("full_occ_after_stall", 64'(occupancy), 64'(DEPTH));
    enq_valid = 1'b0;
    iss_ready = 1'b1;
    step;
    chk("drain1_occ", 64'(occupancy), 64'(DEPTH - 1));
    chk("drain1_enq_ready", 64'(enq_ready), 64'd1);
    wait_drain(20);
    chk("drain_done_valid", 64'(iss_valid), 64'd0);
    chk("drain_done_occ", 64'(occupancy), 64'd0);

    // Flush with 5 queued entries plus a held issue register and an enqueue.
    iss_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_enq(rand_payload(), 6'(k), 6'(k), 1'b0, 1'b0);
      step;
    end
    enq_valid = 1'b0;
    chk("preflush_occ", 64'(occupancy), 64'd5);
    chk("preflush_valid", 64'(iss_valid), 64'd1);
    drive_enq(rand_payload(), 6'd1, 6'd2, 1'b0, 1'b0);
    flush = 1'b1;
    step;
    flush = 1'b0;
    enq_valid = 1'b0;
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_valid", 64'(iss_valid), 64'd0);
    chk("flush_enq_ready", 64'(enq_ready), 64'd1);
    iss_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk($sformatf("postflush_quiet%0d", k), 64'(iss_valid), 64'd0);
    end
    pl = rand_payload();
    drive_enq(pl, 6'd50, 6'd51, 1'b0, 1'b0);
    push(pl);
    step;
    enq_valid = 1'b0;
    wait_drain(5);
    step;

`ifdef ISQ_PERF_CNT_EN
    chk("perf_issue", 64'(perf_issue_cnt), 64'(pushed_total));
    chk("perf_stall", 64'(perf_full_stall_cnt), 64'd3);
`endif

    // Asynchronous reset between edges during traffic.
    iss_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_enq(rand_payload(), 6'(k), 6'(k), 1'b0, 1'b0);
      step;
    end
    chk("prereset_valid", 64'(iss_valid), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(iss_valid), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_enq_ready", 64'(enq_ready), 64'd1);
    chk_d("arst_data", iss_data, '0);
`ifdef ISQ_PERF_CNT_EN
    chk("arst_perf_issue", 64'(perf_issue_cnt), 64'd0);
    chk("arst_perf_stall", 64'(perf_full_stall_cnt), 64'd0);
`endif
    enq_valid = 1'b0;
    step;
    reset_n = 1'b1;
    iss_ready = 1'b1;
    pl = rand_payload();
    drive_enq(pl, 6'd60, 6'd61, 1'b0, 1'b0);
    push(pl);
    step;
    enq_valid = 1'b0;
    wait_drain(5);
    step;
    chk("final_occ", 64'(occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected finish");
    $fatal(1);
  end

endmodule

// File: doc/age_issue_queue.md
Name: age_issue_queue

Overview:
- Parametrised next-generation issue queue between dispatch and a functional unit.
- Entries wake by broadcast physical-register tag match (CAM) on WAKE_PORTS channels, not by index.
- Selects the oldest fully-ready entry via an age matrix.
- Issues through a registered valid/ready output stage; supports full flush.

Parameters:
- DEPTH, 8: number of entries, power of two, >=2.
- DATA_WIDTH, 248: opaque payload width, carried unchanged from dispatch to FU.
- PREG_WIDTH, 6: physical register tag width.
- WAKE_PORTS, 2: number of writeback tag broadcast channels.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enq_valid  in  1  dispatch offers an entry.
- enq_ready  out  1  queue accepts an entry this cycle.
- enq_data  in  DATA_WIDTH  payload.
- enq_prs1  in  PREG_WIDTH  source-1 tag.
- enq_prs2  in  PREG_WIDTH  source-2 tag.
- enq_src1_busy  in  1  source-1 not yet produced.
- enq_src2_busy  in  1  source-2 not yet produced.
- wake_valid  in  WAKE_PORTS  per-channel broadcast valid.
- wake_preg  in  WAKE_PORTS*PREG_WIDTH  per-channel tag; channel k occupies bits [k*PREG_WIDTH +: PREG_WIDTH].
- iss_valid  out  1  issue register holds an instruction.
- iss_ready  in  1  FU accepts the issue register.
- iss_data  out  DATA_WIDTH  issued payload.
- flush  in  1  discard all entries and the issue register.
- occupancy  out  $clog2(DEPTH)+1  count of valid entries, excluding the issue register.

Behaviour:
- Reset values: all entry valid bits 0; age matrix 0; iss_valid=0; iss_data=0; occupancy=0.
- enq_ready = (occupancy != DEPTH). It depends only on registered state and does not count a same-cycle dequeue.
- Enqueue fires when enq_valid && enq_ready. The entry goes to the lowest-index free slot. Its age row is set so that it is younger than every currently valid entry.
- Entry busy bits:
  - stored busy = enq_srcN_busy && no wake channel matching enq_prsN in the same cycle (enqueue bypass wakeup).
  - Each cycle, any valid entry whose prsN equals a valid wake_preg clears busyN.
  - Multiple matching channels are harmless.
- Ready entry: valid && !busy1 && !busy2.
- Select: the oldest ready entry, i.e. the one whose age row shows no older ready entry. Combinational.
- Issue register load: when (!iss_valid || iss_ready) and a ready entry exists:
  - iss_data <= entry payload; iss_valid <= 1; the entry's valid bit is cleared.
  - Otherwise, if iss_ready, iss_valid <= 0.
- Output stability: iss_data and iss_valid stay stable while iss_valid && !iss_ready.
- Latency: an entry enqueued ready at edge N is visible on iss_valid after edge N+1. There is no enqueue-to-issue bypass.
- Simultaneous enqueue and issue: the freed slot is not reused in the same cycle. occupancy updates by +enq -iss.
- Wakeup arriving in the same cycle as selection does not affect that cycle's selection (busy bits are registered).
- flush (highest priority):
  - Clears all valid bits, the age matrix and iss_valid on the next edge.
  - Enqueue and issue in that cycle are dropped.
  - occupancy <= 0.
- reset_n deasserted mid-operation: immediate return to reset values, regardless of clock.

Optional Feature:
- Macro ISQ_PERF_CNT_EN.
- When defined, adds outputs perf_issue_cnt (32) and perf_full_stall_cnt (32):
  - perf_issue_cnt increments on each iss_valid && iss_ready.
  - perf_full_stall_cnt increments on each enq_valid && !enq_ready.
  - Both wrap at 2^32, reset to 0, and are unaffected by flush.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package isq_pkg: ISQ_PREG_WIDTH default, the entry struct typedef (valid, busy1, busy2, prs1, prs2, payload), and a clog2-derived index-width constant.
- One sub-module: isq_age_matrix (DEPTH). Inputs: alloc one-hot, free one-hot, request vector. Outputs: oldest-grant one-hot. Keeps ordering logic separately testable.

Test Plan:
- Enqueue 3 entries with both sources ready, iss_ready=1 -> issued in enqueue order A,B,C on 3 consecutive cycles; first iss_valid one cycle after A's enqueue edge.
- Enqueue A (prs1=5 busy), then B (ready); broadcast wake_preg=5 two cycles later -> B issues first, A issues the cycle after its wakeup edge.
- Enqueue with enq_prs2=9 busy while wake channel 1 carries 9 in the same cycle -> entry stored ready, issues next cycle.
- Fill 8 entries with iss_ready=0 -> enq_ready=0 and occupancy=8; hold iss_valid with stable iss_data 3 cycles; raise iss_ready -> one drain per cycle, enq_ready=1 after first dequeue edge.
- Assert flush with 5 entries valid and iss_valid=1 while enq_valid=1 -> next cycle occupancy=0, iss_valid=0, nothing issues afterwards.
- Assert reset_n low between clock edges during traffic -> iss_valid and occupancy go 0 immediately; with ISQ_PERF_CNT_EN, counters read 0.
